// File: rtl/cpu_controller_pkg.sv
// -----------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared definitions for the cpu_controller slice:
//   - state_t       : controller FSM state encoding (S_HALT is only reachable
//                     when CPU_CTRL_ILLEGAL_TRAP_EN is defined)
//   - instr_kind_t  : decoded instruction class
//   - opcode / op constants for the legal instruction set
//   - bit positions of every instruction-register field
//   - sign_ext8()   : imm8 -> 16-bit sign extension
// -----------------------------------------------------------------------------
package cpu_ctrl_pkg;

   typedef enum logic [2:0] {
      S_WAIT      = 3'd0,
      S_DECODE    = 3'd1,
      S_WRITE_IMM = 3'd2,
      S_GET_A     = 3'd3,
      S_GET_B     = 3'd4,
      S_ALU       = 3'd5,
      S_WRITE_REG = 3'd6,
      S_HALT      = 3'd7
   } state_t;

   typedef enum logic [2:0] {
      K_ILLEGAL = 3'd0,
      K_MOV_IMM = 3'd1,
      K_MOV_REG = 3'd2,
      K_ADD     = 3'd3,
      K_CMP     = 3'd4,
      K_AND     = 3'd5,
      K_MVN     = 3'd6
   } instr_kind_t;

   // Opcode field values
   localparam logic [2:0] OPC_MOV = 3'b110;
   localparam logic [2:0] OPC_ALU = 3'b101;

   // op field values under OPC_MOV
   localparam logic [1:0] OP_MOV_IMM = 2'b10;
   localparam logic [1:0] OP_MOV_REG = 2'b00;

   // op field values under OPC_ALU (also the ALUop encoding)
   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_CMP = 2'b01;
   localparam logic [1:0] OP_AND = 2'b10;
   localparam logic [1:0] OP_MVN = 2'b11;

   // Instruction-register field bit positions
   localparam int OPC_HI = 15;
   localparam int OPC_LO = 13;
   localparam int OP_HI  = 12;
   localparam int OP_LO  = 11;
   localparam int RN_HI  = 10;
   localparam int RN_LO  = 8;
   localparam int RD_HI  = 7;
   localparam int RD_LO  = 5;
   localparam int SH_HI  = 4;
   localparam int SH_LO  = 3;
   localparam int RM_HI  = 2;
   localparam int RM_LO  = 0;
   localparam int IMM_HI = 7;
   localparam int IMM_LO = 0;

   function automatic logic [15:0] sign_ext8(input logic [7:0] v);
      return {{8{v[7]}}, v};
   endfunction

endpackage

// File: rtl/cpu_controller_if.sv
// -----------------------------------------------------------------------------
// cpu_controller_if
// Bundles the controller's command inputs and datapath control outputs.
//   master : the controller (consumes s/load/in, drives all controls)
//   slave  : the surrounding system / datapath (drives s/load/in)
//
// Command semantics: s and load are level strobes sampled on the rising edge
// of clk, and only while the controller reports idle (w=1). load=1 captures
// in[15:0] into the instruction register; s=1 starts execution of the held
// instruction (or of the word captured on that same edge when both are high).
// While w=0 both strobes are ignored, so no back-pressure is needed.
// -----------------------------------------------------------------------------
interface cpu_controller_if;

   logic        s;
   logic        load;
   logic [15:0] in;

   logic        w;
   logic        illegal;
   logic        write;
   logic        vsel;
   logic        loada;
   logic        loadb;
   logic        loadc;
   logic        loads;
   logic        asel;
   logic        bsel;
   logic [2:0]  readnum;
   logic [2:0]  writenum;
   logic [1:0]  shift;
   logic [1:0]  ALUop;
   logic [15:0] sximm8;

   modport master (
      input  s, load, in,
      output w, illegal, write, vsel, loada, loadb, loadc, loads,
             asel, bsel, readnum, writenum, shift, ALUop, sximm8
   );

   modport slave (
      output s, load, in,
      input  w, illegal, write, vsel, loada, loadb, loadc, loads,
             asel, bsel, readnum, writenum, shift, ALUop, sximm8
   );

endinterface

// File: rtl/cpu_controller_instr_decoder.sv
// -----------------------------------------------------------------------------
// instr_decoder
// Purely combinational split of the 16-bit instruction register.
// Ports:
//   ir      in  16  instruction register
//   op      out 2   op field
//   rn/rd/rm out 3  register index fields
//   sh      out 2   shifter code field
//   sximm8  out 16  sign-extended imm8
//   kind    out     decoded instruction class (K_ILLEGAL when undefined)
//   legal   out 1   1 when the opcode/op pair is in the legal set
// -----------------------------------------------------------------------------
module instr_decoder
   import cpu_ctrl_pkg::*;
(
   input  logic [15:0] ir,
   output logic [1:0]  op,
   output logic [2:0]  rn,
   output logic [2:0]  rd,
   output logic [2:0]  rm,
   output logic [1:0]  sh,
   output logic [15:0] sximm8,
   output instr_kind_t kind,
   output logic        legal
);

   logic [2:0] opcode;
   logic [7:0] imm8;

   assign opcode = ir[OPC_HI:OPC_LO];
   assign op     = ir[OP_HI:OP_LO];
   assign rn     = ir[RN_HI:RN_LO];
   assign rd     = ir[RD_HI:RD_LO];
   assign sh     = ir[SH_HI:SH_LO];
   assign rm     = ir[RM_HI:RM_LO];
   assign imm8   = ir[IMM_HI:IMM_LO];
   assign sximm8 = sign_ext8(imm8);

   always_comb begin
      kind = K_ILLEGAL;
      case (opcode)
         OPC_MOV: begin
            case (op)
               OP_MOV_IMM: kind = K_MOV_IMM;
               OP_MOV_REG: kind = K_MOV_REG;
               default:    kind = K_ILLEGAL;
            endcase
         end
         OPC_ALU: begin
            case (op)
               OP_ADD:  kind = K_ADD;
               OP_CMP:  kind = K_CMP;
               OP_AND:  kind = K_AND;
               default: kind = K_MVN;
            endcase
         end
         default: kind = K_ILLEGAL;
      endcase
   end

   assign legal = (kind != K_ILLEGAL);

endmodule

// File: rtl/cpu_controller.sv
// -----------------------------------------------------------------------------
// cpu_controller
// Multi-cycle control FSM for a small register/ALU datapath. Holds the
// instruction register, decodes it through instr_decoder and sequences the
// datapath load/write strobes one state per cycle.
// Ports:
//   clk      in   1  clock, rising edge
//   reset_n  in   1  asynchronous active-low reset
//   bus      cpu_controller_if.master  commands in, datapath controls out
//   state    out  state_t  current FSM state (debug/observation)
// Build option:
//   CPU_CTRL_ILLEGAL_TRAP_EN  defined   -> undefined instruction parks the
//                                          FSM in S_HALT (w=0, illegal held
//                                          high) until reset
//                             undefined -> one-cycle illegal pulse, back to
//                                          S_WAIT
// -----------------------------------------------------------------------------
module cpu_controller
   import cpu_ctrl_pkg::*;
(
   input  logic                     clk,
   input  logic                     reset_n,
   cpu_controller_if.master         bus,
   output state_t                   state
);

   state_t      state_q;
   logic [15:0] ir_q;

   logic w_q, illegal_q, write_q, vsel_q;
   logic loada_q, loadb_q, loadc_q, loads_q, asel_q;

   logic [1:0]  op;
   logic [2:0]  rn, rd, rm;
   logic [1:0]  sh;
   logic [15:0] sximm8;
   instr_kind_t kind;
   logic        legal;

   instr_decoder u_dec (
      .ir     (ir_q),
      .op     (op),
      .rn     (rn),
      .rd     (rd),
      .rm     (rm),
      .sh     (sh),
      .sximm8 (sximm8),
      .kind   (kind),
      .legal  (legal)
   );

   // Strobes are registered together with the state they belong to, so each
   // one is high exactly while state_q holds the matching state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_WAIT;
         ir_q      <= '0;
         w_q       <= 1'b1;
         illegal_q <= 1'b0;
         write_q   <= 1'b0;
         vsel_q    <= 1'b0;
         loada_q   <= 1'b0;
         loadb_q   <= 1'b0;
         loadc_q   <= 1'b0;
         loads_q   <= 1'b0;
         asel_q    <= 1'b0;
      end else begin
         w_q       <= 1'b0;
         illegal_q <= 1'b0;
         write_q   <= 1'b0;
         vsel_q    <= 1'b0;
         loada_q   <= 1'b0;
         loadb_q   <= 1'b0;
         loadc_q   <= 1'b0;
         loads_q   <= 1'b0;
         asel_q    <= 1'b0;

         case (state_q)
            S_WAIT: begin
               // IR is only writable here, so it is stable during execution.
               if (bus.load) ir_q <= bus.in;
               if (bus.s) begin
                  state_q <= S_DECODE;
               end else begin
                  w_q <= 1'b1;
               end
            end

            S_DECODE: begin
               if (!legal) begin
                  illegal_q <= 1'b1;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
                  state_q   <= S_HALT;
`else
                  state_q   <= S_WAIT;
                  w_q       <= 1'b1;
`endif
               end else begin
                  case (kind)
                     K_MOV_IMM: begin
                        state_q <= S_WRITE_IMM;
                        write_q <= 1'b1;
                        vsel_q  <= 1'b1;
                     end
                     K_ADD, K_CMP, K_AND: begin
                        state_q <= S_GET_A;
                        loada_q <= 1'b1;
                     end
                     K_MOV_REG, K_MVN: begin
                        state_q <= S_GET_B;
                        loadb_q <= 1'b1;
                     end
                     default: begin
                        state_q <= S_WAIT;
                        w_q     <= 1'b1;
                     end
                  endcase
               end
            end

            S_WRITE_IMM: begin
               state_q <= S_WAIT;
               w_q     <= 1'b1;
            end

            S_GET_A: begin
               state_q <= S_GET_B;
               loadb_q <= 1'b1;
            end

            S_GET_B: begin
               // CMP only updates status; MOV reg passes B through with A=0.
               state_q <= S_ALU;
               loadc_q <= (kind != K_CMP);
               loads_q <= (kind == K_CMP);
               asel_q  <= (kind == K_MOV_REG);
            end

            S_ALU: begin
               if (kind == K_CMP) begin
                  state_q <= S_WAIT;
                  w_q     <= 1'b1;
               end else begin
                  state_q <= S_WRITE_REG;
                  write_q <= 1'b1;
               end
            end

            S_WRITE_REG: begin
               state_q <= S_WAIT;
               w_q     <= 1'b1;
            end

            S_HALT: begin
               // Trap: held until reset_n.
               state_q   <= S_HALT;
               illegal_q <= 1'b1;
            end

            default: begin
               state_q <= S_WAIT;
               w_q     <= 1'b1;
            end
         endcase
      end
   end

   assign state = state_q;

   assign bus.w       = w_q;
   assign bus.illegal = illegal_q;
   assign bus.write   = write_q;
   assign bus.vsel    = vsel_q;
   assign bus.loada   = loada_q;
   assign bus.loadb   = loadb_q;
   assign bus.loadc   = loadc_q;
   assign bus.loads   = loads_q;
   assign bus.asel    = asel_q;

   // Every supported instruction uses the shifted-B path.
   assign bus.bsel    = 1'b0;

   // IR-derived values stay valid in every state; only the read/write index
   // choice depends on which operand the current state is handling.
   assign bus.readnum  = (state_q == S_GET_A) ? rn : rm;
   assign bus.writenum = (state_q == S_WRITE_IMM) ? rn : rd;
   assign bus.shift    = sh;
   assign bus.ALUop    = (kind == K_MOV_REG) ? OP_ADD : op;
   assign bus.sximm8   = sximm8;

endmodule

// File: tb/tb_cpu_controller.sv
module tb_cpu_controller;
   import cpu_ctrl_pkg::*;

   // Strobe vector bit order: {w, illegal, write, vsel, loada, loadb, loadc, loads, asel, bsel}
   localparam logic [9:0] ST_NONE    = 10'b0000000000;
   localparam logic [9:0] ST_WAIT    = 10'b1000000000;
   localparam logic [9:0] ST_WIMM    = 10'b0011000000;
   localparam logic [9:0] ST_GETA    = 10'b0000100000;
   localparam logic [9:0] ST_GETB    = 10'b0000010000;
   localparam logic [9:0] ST_ALU_C   = 10'b0000001000;
   localparam logic [9:0] ST_ALU_S   = 10'b0000000100;
   localparam logic [9:0] ST_ALU_MOV = 10'b0000001010;
   localparam logic [9:0] ST_WREG    = 10'b0010000000;
   localparam logic [9:0] ST_ILL     = 10'b1100000000;
   localparam logic [9:0] ST_HALT    = 10'b0100000000;

   logic   clk;
   logic   reset_n;
   state_t dbg_state;

   int n_checks = 0;
   int n_errors = 0;

   logic [9:0] exp_q[$];

   cpu_controller_if bus();

   cpu_controller dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus),
      .state   (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input logic [15:0] instr);
      bus.in   = instr;
      bus.load = 1'b1;
      bus.s    = 1'b1;
      tick();
      bus.load = 1'b0;
      bus.s    = 1'b0;
   endtask

   task automatic pulse_reset();
      reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   function automatic logic [9:0] strobes();
      return {bus.w, bus.illegal, bus.write, bus.vsel, bus.loada, bus.loadb,
              bus.loadc, bus.loads, bus.asel, bus.bsel};
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      bus.s    = 1'b0;
      bus.load = 1'b1;
      bus.in   = 16'hFFFF;
      reset_n  = 1'b0;
      tick();
      tick();
      n_checks++;
      if (strobes() !== ST_WAIT) begin
         n_errors++;
         $display("FAIL reset_strobes got=%b exp=%b", strobes(), ST_WAIT);
      end
      n_checks++;
      if (dbg_state !== S_WAIT) begin
         n_errors++;
         $display("FAIL reset_state got=%0d exp=%0d", dbg_state, S_WAIT);
      end
      n_checks++;
      if (bus.sximm8 !== 16'h0000) begin
         n_errors++;
         $display("FAIL reset_ir got=%h exp=0000", bus.sximm8);
      end
      bus.load = 1'b0;
      reset_n  = 1'b1;
      tick();
   endtask

   task automatic test_load_only();
      bus.in   = 16'hD005;
      bus.load = 1'b1;
      tick();
      bus.load = 1'b0;
      n_checks++;
      if (dbg_state !== S_WAIT || bus.w !== 1'b1) begin
         n_errors++;
         $display("FAIL load_only_state got=%0d w=%b exp=%0d w=1", dbg_state, bus.w, S_WAIT);
      end
      n_checks++;
      if (bus.sximm8 !== 16'h0005) begin
         n_errors++;
         $display("FAIL load_only_ir got=%h exp=0005", bus.sximm8);
      end
   endtask

   task automatic test_mov_imm();
      logic [9:0] exp_v;
      int cyc;
      exp_q = {ST_NONE, ST_WIMM, ST_WAIT};
      start(16'hD007);
      cyc = 0;
      while (exp_q.size() > 0) begin
         exp_v = exp_q.pop_front();
         n_checks++;
         if (strobes() !== exp_v) begin
            n_errors++;
            $display("FAIL mov_imm_strobes cyc=%0d got=%b exp=%b", cyc, strobes(), exp_v);
         end
         if (cyc == 1) begin
            n_checks++;
            if (bus.writenum !== 3'd0 || bus.sximm8 !== 16'h0007) begin
               n_errors++;
               $display("FAIL mov_imm_fields got=%0d/%h exp=0/0007", bus.writenum, bus.sximm8);
            end
         end
         if (exp_q.size() > 0) tick();
         cyc++;
      end
   endtask

   task automatic test_add();
      logic [9:0] exp_v;
      int cyc;
      exp_q = {ST_NONE, ST_GETA, ST_GETB, ST_ALU_C, ST_WREG, ST_WAIT};
      start(16'hA148);
      cyc = 0;
      while (exp_q.size() > 0) begin
         exp_v = exp_q.pop_front();
         n_checks++;
         if (strobes() !== exp_v) begin
            n_errors++;
            $display("FAIL add_strobes cyc=%0d got=%b exp=%b", cyc, strobes(), exp_v);
         end
         if (cyc == 1) begin
            n_checks++;
            if (bus.readnum !== 3'd1) begin
               n_errors++;
               $display("FAIL add_readnum_a got=%0d exp=1", bus.readnum);
            end
         end
         if (cyc == 2) begin
            n_checks++;
            if (bus.readnum !== 3'd0) begin
               n_errors++;
               $display("FAIL add_readnum_b got=%0d exp=0", bus.readnum);
            end
         end
         if (cyc == 3) begin
            n_checks++;
            if (bus.shift !== 2'b01 || bus.ALUop !== 2'b00) begin
               n_errors++;
               $display("FAIL add_alu got=%b/%b exp=01/00", bus.shift, bus.ALUop);
            end
         end
         if (cyc == 4) begin
            n_checks++;
            if (bus.writenum !== 3'd2) begin
               n_errors++;
               $display("FAIL add_writenum got=%0d exp=2", bus.writenum);
            end
         end
         if (exp_q.size() > 0) tick();
         cyc++;
      end
   endtask

   task automatic test_cmp();
      logic [9:0] exp_v;
      int cyc;
      exp_q = {ST_NONE, ST_GETA, ST_GETB, ST_ALU_S, ST_WAIT};
      start(16'hAB04);
      cyc = 0;
      while (exp_q.size() > 0) begin
         exp_v = exp_q.pop_front();
         n_checks++;
         if (strobes() !== exp_v) begin
            n_errors++;
            $display("FAIL cmp_strobes cyc=%0d got=%b exp=%b", cyc, strobes(), exp_v);
         end
         if (cyc == 1) begin
            n_checks++;
            if (bus.readnum !== 3'd3) begin
               n_errors++;
               $display("FAIL cmp_readnum_a got=%0d exp=3", bus.readnum);
            end
         end
         if (cyc == 2) begin
            n_checks++;
            if (bus.readnum !== 3'd4) begin
               n_errors++;
               $display("FAIL cmp_readnum_b got=%0d exp=4", bus.readnum);
            end
         end
         if (cyc == 3) begin
            n_checks++;
            if (bus.ALUop !== 2'b01) begin
               n_errors++;
               $display("FAIL cmp_aluop got=%b exp=01", bus.ALUop);
            end
         end
         if (exp_q.size() > 0) tick();
         cyc++;
      end
   endtask

   task automatic test_and();
      logic [9:0] exp_v;
      int cyc;
      exp_q = {ST_NONE, ST_GETA, ST_GETB, ST_ALU_C, ST_WREG, ST_WAIT};
      start(16'hB27C);
      cyc = 0;
      while (exp_q.size() > 0) begin
         exp_v = exp_q.pop_front();
         n_checks++;
         if (strobes() !== exp_v) begin
            n_errors++;
            $display("FAIL and_strobes cyc=%0d got=%b exp=%b", cyc, strobes(), exp_v);
         end
         if (cyc == 3) begin
            n_checks++;
            if (bus.shift !== 2'b11 || bus.ALUop !== 2'b10) begin
               n_errors++;
               $display("FAIL and_alu got=%b/%b exp=11/10", bus.shift, bus.ALUop);
            end
         end
         if (cyc == 4) begin
            n_checks++;
            if (bus.writenum !== 3'd3) begin
               n_errors++;
               $display("FAIL and_writenum got=%0d exp=3", bus.writenum);
            end
         end
         if (exp_q.size() > 0) tick();
         cyc++;
      end
   endtask

   task automatic test_mvn();
      logic [9:0] exp_v;
      int cyc;
      exp_q = {ST_NONE, ST_GETB, ST_ALU_C, ST_WREG, ST_WAIT};
      start(16'hB8A6);
      cyc = 0;
      while (exp_q.size() > 0) begin
         exp_v = exp_q.pop_front();
         n_checks++;
         if (strobes() !== exp_v) begin
            n_errors++;
            $display("FAIL mvn_strobes cyc=%0d got=%b exp=%b", cyc, strobes(), exp_v);
         end
         if (cyc == 1) begin
            n_checks++;
            if (bus.readnum !== 3'd6) begin
               n_errors++;
               $display("FAIL mvn_readnum got=%0d exp=6", bus.readnum);
            end
         end
         if (cyc == 2) begin
            n_checks++;
            if (bus.ALUop !== 2'b11) begin
               n_errors++;
               $display("FAIL mvn_aluop got=%b exp=11", bus.ALUop);
            end
         end
         if (cyc == 3) begin
            n_checks++;
            if (bus.writenum !== 3'd5) begin
               n_errors++;
               $display("FAIL mvn_writenum got=%0d exp=5", bus.writenum);
            end
         end
         if (exp_q.size() > 0) tick();
         cyc++;
      end
   endtask

   task automatic test_mov_reg();
      logic [9:0] exp_v;
      int cyc;
      exp_q = {ST_NONE, ST_GETB, ST_ALU_MOV, ST_WREG, ST_WAIT};
      start(16'hC0F1);
      cyc = 0;
      while (exp_q.size() > 0) begin
         exp_v = exp_q.pop_front();
         n_checks++;
         if (strobes() !== exp_v) begin
            n_errors++;
            $display("FAIL mov_reg_strobes cyc=%0d got=%b exp=%b", cyc, strobes(), exp_v);
         end
         if (cyc == 1) begin
            n_checks++;
            if (bus.readnum !== 3'd1) begin
               n_errors++;
               $display("FAIL mov_reg_readnum got=%0d exp=1", bus.readnum);
            end
         end
         if (cyc == 2) begin
            n_checks++;
            if (bus.shift !== 2'b10 || bus.ALUop !== 2'b00) begin
               n_errors++;
               $display("FAIL mov_reg_alu got=%b/%b exp=10/00", bus.shift, bus.ALUop);
            end
         end
         if (cyc == 3) begin
            n_checks++;
            if (bus.writenum !== 3'd7) begin
               n_errors++;
               $display("FAIL mov_reg_writenum got=%0d exp=7", bus.writenum);
            end
         end
         if (exp_q.size() > 0) tick();
         cyc++;
      end
   endtask

   task automatic test_illegal();
      logic [15:0] instrs [3];
      logic [9:0]  exp_v;
      int cyc;
      instrs[0] = 16'hE000;
      instrs[1] = 16'hC800;
      instrs[2] = 16'hD800;
      for (int k = 0; k < 3; k++) begin
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
         exp_q = {ST_NONE, ST_HALT, ST_HALT, ST_HALT};
`else
         exp_q = {ST_NONE, ST_ILL, ST_WAIT};
`endif
         start(instrs[k]);
         cyc = 0;
         while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            n_checks++;
            if (strobes() !== exp_v) begin
               n_errors++;
               $display("FAIL illegal_strobes ir=%h cyc=%0d got=%b exp=%b", instrs[k], cyc, strobes(), exp_v);
            end
            if (exp_q.size() > 0) tick();
            cyc++;
         end
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
         pulse_reset();
`endif
      end
   endtask

   task automatic test_s_ignored();
      logic [9:0] exp_v;
      int cyc;
      exp_q = {ST_NONE, ST_GETA, ST_GETB, ST_ALU_C, ST_WREG, ST_WAIT};
      start(16'hA148);
      cyc = 0;
      while (exp_q.size() > 0) begin
         exp_v = exp_q.pop_front();
         if (cyc == 1) begin
            bus.s    = 1'b1;
            bus.load = 1'b1;
            bus.in   = 16'hE000;
         end
         if (cyc == 3) begin
            bus.s    = 1'b0;
            bus.load = 1'b0;
         end
         n_checks++;
         if (strobes() !== exp_v) begin
            n_errors++;
            $display("FAIL s_ignored_strobes cyc=%0d got=%b exp=%b", cyc, strobes(), exp_v);
         end
         if (cyc == 4) begin
            n_checks++;
            if (bus.writenum !== 3'd2 || bus.sximm8 !== 16'h0048) begin
               n_errors++;
               $display("FAIL s_ignored_ir got=%0d/%h exp=2/0048", bus.writenum, bus.sximm8);
            end
         end
         if (exp_q.size() > 0) tick();
         cyc++;
      end
      tick();
      n_checks++;
      if (dbg_state !== S_WAIT) begin
         n_errors++;
         $display("FAIL s_ignored_idle got=%0d exp=%0d", dbg_state, S_WAIT);
      end
   endtask

   task automatic test_reset_mid();
      start(16'hA148);
      tick();
      tick();
      n_checks++;
      if (dbg_state !== S_GET_B) begin
         n_errors++;
         $display("FAIL reset_mid_pre got=%0d exp=%0d", dbg_state, S_GET_B);
      end
      reset_n = 1'b0;
      #1;
      n_checks++;
      if (dbg_state !== S_WAIT || strobes() !== ST_WAIT) begin
         n_errors++;
         $display("FAIL reset_mid_async got=%0d/%b exp=%0d/%b", dbg_state, strobes(), S_WAIT, ST_WAIT);
      end
      n_checks++;
      if (bus.sximm8 !== 16'h0000) begin
         n_errors++;
         $display("FAIL reset_mid_ir got=%h exp=0000", bus.sximm8);
      end
      for (int k = 0; k < 3; k++) begin
         tick();
         n_checks++;
         if (bus.write !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid_write cyc=%0d got=%b exp=0", k, bus.write);
         end
      end
      // Release together with a start: the first s after reset is honoured.
      reset_n  = 1'b1;
      bus.in   = 16'hD1FF;
      bus.load = 1'b1;
      bus.s    = 1'b1;
      tick();
      bus.load = 1'b0;
      bus.s    = 1'b0;
      n_checks++;
      if (dbg_state !== S_DECODE) begin
         n_errors++;
         $display("FAIL reset_first_s got=%0d exp=%0d", dbg_state, S_DECODE);
      end
      tick();
      n_checks++;
      if (strobes() !== ST_WIMM || bus.writenum !== 3'd1 || bus.sximm8 !== 16'hFFFF) begin
         n_errors++;
         $display("FAIL mov_imm_neg got=%b/%0d/%h exp=%b/1/ffff", strobes(), bus.writenum, bus.sximm8, ST_WIMM);
      end
      tick();
      n_checks++;
      if (strobes() !== ST_WAIT) begin
         n_errors++;
         $display("FAIL mov_imm_neg_done got=%b exp=%b", strobes(), ST_WAIT);
      end
   endtask

   task automatic test_back_to_back();
      start(16'hD007);
      tick();
      n_checks++;
      if (dbg_state !== S_WRITE_IMM) begin
         n_errors++;
         $display("FAIL b2b_first got=%0d exp=%0d", dbg_state, S_WRITE_IMM);
      end
      tick();
      // Idle cycle: start the next instruction immediately.
      start(16'hAB04);
      n_checks++;
      if (dbg_state !== S_DECODE) begin
         n_errors++;
         $display("FAIL b2b_second got=%0d exp=%0d", dbg_state, S_DECODE);
      end
      tick();
      n_checks++;
      if (dbg_state !== S_GET_A || bus.readnum !== 3'd3) begin
         n_errors++;
         $display("FAIL b2b_second_geta got=%0d/%0d exp=%0d/3", dbg_state, bus.readnum, S_GET_A);
      end
      repeat (3) tick();
      n_checks++;
      if (dbg_state !== S_WAIT) begin
         n_errors++;
         $display("FAIL b2b_done got=%0d exp=%0d", dbg_state, S_WAIT);
      end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      reset_n  = 1'b0;
      bus.s    = 1'b0;
      bus.load = 1'b0;
      bus.in   = 16'h0000;
      test_reset();
      test_load_only();
      test_mov_imm();
      test_add();
      test_cmp();
      test_and();
      test_mvn();
      test_mov_reg();
      test_illegal();
      test_s_ignored();
      test_reset_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
